// File: rtl/digit_serial_addsub_pkg.sv
// digit_serial_addsub_pkg
//   Shared definitions for the digit-serial adder/subtractor: FSM state
//   encoding and helpers that derive the digit count and the width of
//   the digit-index register from the WIDTH/DIGIT parameters.
package digit_serial_addsub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Number of digits in an operand (WIDTH must be a multiple of DIGIT).
  function automatic int ndig(input int width, input int digit);
    return width / digit;
  endfunction

  // Index register width: clog2(n), never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/digit_serial_addsub_digit_adder.sv
// digit_adder
//   DIGIT-bit combinational ripple-carry chain, reused every cycle by the
//   digit-serial datapath.
//   a_d, b_d : digit operands      c_in  : carry into bit 0
//   s_d      : digit sum           c_out : carry out of the top bit
module digit_adder #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] a_d,
  input  logic [DIGIT-1:0] b_d,
  input  logic             c_in,
  output logic [DIGIT-1:0] s_d,
  output logic             c_out
);

  logic c;

  always_comb begin
    s_d = '0;
    c   = c_in;
    for (int unsigned k = 0; k < DIGIT; k++) begin
      s_d[k] = a_d[k] ^ b_d[k] ^ c;
      c      = (a_d[k] & b_d[k]) | (c & (a_d[k] ^ b_d[k]));
    end
    c_out = c;
  end

endmodule

// File: rtl/digit_serial_addsub.sv
// digit_serial_addsub
//   Multi-cycle WIDTH-bit adder/subtractor processing DIGIT bits per clock
//   through a single shared carry chain, with valid/ready on both sides.
//   clk, rst_n          : clock (rising edge), async active-low reset
//   in_valid/in_ready   : operand handshake (accepted only in IDLE)
//   a, b, cin, sub      : operands, carry/borrow-in, 0=add 1=subtract
//   out_valid/out_ready : result handshake (held in DONE until taken)
//   sum, cout, ovf, zero: result, carry/not-borrow, signed overflow, zero
module digit_serial_addsub
  import digit_serial_addsub_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int NDIG = ndig(WIDTH, DIGIT);
  localparam int IW   = idx_width(NDIG);
  localparam logic [IW-1:0] LAST = IW'(NDIG - 1);

  state_t           state;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;    // b already inverted for subtraction
  logic             carry;
  logic [IW-1:0]    idx;

  logic [DIGIT-1:0] a_d;
  logic [DIGIT-1:0] b_d;
  logic [DIGIT-1:0] s_d;
  logic             c_out;
  logic [WIDTH-1:0] sum_nx;

  // sum_nx is the result register with the current digit merged in; on the
  // last digit it is the complete result, so zero is taken from it.
  always_comb begin
    a_d    = a_r[int'(idx) * DIGIT +: DIGIT];
    b_d    = b_r[int'(idx) * DIGIT +: DIGIT];
    sum_nx = sum;
    sum_nx[int'(idx) * DIGIT +: DIGIT] = s_d;
  end

  digit_adder #(.DIGIT(DIGIT)) u_digit_adder (
    .a_d   (a_d),
    .b_d   (b_d),
    .c_in  (carry),
    .s_d   (s_d),
    .c_out (c_out)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      a_r       <= '0;
      b_r       <= '0;
      carry     <= 1'b0;
      idx       <= '0;
      sum       <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
      zero      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_r      <= a;
            b_r      <= sub ? ~b : b;
            carry    <= sub ? ~cin : cin;
            idx      <= '0;
            in_ready <= 1'b0;
            state    <= RUN;
          end
        end
        RUN: begin
          sum   <= sum_nx;
          carry <= c_out;
          if (idx == LAST) begin
            cout      <= c_out;
            ovf       <= (a_r[WIDTH-1] == b_r[WIDTH-1]) && (s_d[DIGIT-1] != a_r[WIDTH-1]);
            zero      <= (sum_nx == '0);
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            idx <= idx + IW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_digit_serial_addsub.sv
// tb_digit_serial_addsub
//   Three instances (DIGIT = 4, 16, 1 at WIDTH = 16). Instance 0 runs the
//   directed vectors, backpressure and mid-operation reset; instances 1 and
//   2 run random operands against an integer reference model. Stimulus
//   pushes expected results into a per-instance queue; a monitor pops and
//   compares whenever out_valid rises.
module tb_digit_serial_addsub;

  localparam int W = 16;
  localparam int DIG [3] = '{4, 16, 1};

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    logic         zero;
    int           t_acc;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;
  bit done [3] = '{0, 0, 0};

  logic         rst_n     [3];
  logic         in_valid  [3];
  logic         in_ready  [3];
  logic [W-1:0] a         [3];
  logic [W-1:0] b         [3];
  logic         cin       [3];
  logic         sub       [3];
  logic         out_valid [3];
  logic         out_ready [3];
  logic [W-1:0] sum       [3];
  logic         cout      [3];
  logic         ovf       [3];
  logic         zero      [3];

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endfunction

  function automatic exp_t mk(input logic [W-1:0] s, input logic c, input logic o, input logic z);
    exp_t e;
    e.sum = s; e.cout = c; e.ovf = o; e.zero = z; e.t_acc = 0;
    return e;
  endfunction

  // Reference using plain integer arithmetic, signed and unsigned.
  function automatic exp_t model(input logic [W-1:0] ta, input logic [W-1:0] tb,
                                 input logic tc, input logic ts);
    int ua, ub, sa, sb, ur, sr;
    exp_t e;
    ua = int'(ta); ub = int'(tb);
    sa = int'($signed(ta)); sb = int'($signed(tb));
    if (ts) begin
      ur = ua - ub - int'(tc);
      sr = sa - sb - int'(tc);
      e.cout = (ur >= 0);
    end else begin
      ur = ua + ub + int'(tc);
      sr = sa + sb + int'(tc);
      e.cout = (ur > 65535);
    end
    e.sum   = ur[W-1:0];
    e.ovf   = (sr > 32767) || (sr < -32768);
    e.zero  = (e.sum == '0);
    e.t_acc = 0;
    return e;
  endfunction

  for (genvar g = 0; g < 3; g++) begin : u
    localparam int NDIG = W / DIG[g];
    exp_t q[$];
    logic prev_ov = 1'b0;
    exp_t me;

    digit_serial_addsub #(.WIDTH(W), .DIGIT(DIG[g])) dut (
      .clk       (clk),
      .rst_n     (rst_n[g]),
      .in_valid  (in_valid[g]),
      .in_ready  (in_ready[g]),
      .a         (a[g]),
      .b         (b[g]),
      .cin       (cin[g]),
      .sub       (sub[g]),
      .out_valid (out_valid[g]),
      .out_ready (out_ready[g]),
      .sum       (sum[g]),
      .cout      (cout[g]),
      .ovf       (ovf[g]),
      .zero      (zero[g])
    );

    task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc,
                        input logic ts, input bit push, input exp_t e);
      int n = 0;
      while (!in_ready[g] && n < 200) begin
        @(negedge clk);
        n++;
      end
      if (!in_ready[g]) begin
        checks++;
        errors++;
        $display("FAIL u%0d in_ready_timeout: got 0, expected 1", g);
      end
      a[g] = ta; b[g] = tb; cin[g] = tc; sub[g] = ts; in_valid[g] = 1'b1;
      @(posedge clk);
      #1;
      in_valid[g] = 1'b0;
      e.t_acc = cyc;
      if (push) q.push_back(e);
    endtask

    task automatic drain();
      int n = 0;
      while (q.size() != 0 && n < 200) begin
        @(negedge clk);
        n++;
      end
      chk($sformatf("u%0d pending_results", g), q.size(), 0);
    endtask

    always @(negedge clk) begin
      if (out_valid[g] && !prev_ov) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL u%0d unexpected_result: got sum %0h, expected no result", g, sum[g]);
        end else begin
          me = q.pop_front();
          chk($sformatf("u%0d sum", g),     sum[g],          me.sum);
          chk($sformatf("u%0d cout", g),    cout[g],         me.cout);
          chk($sformatf("u%0d ovf", g),     ovf[g],          me.ovf);
          chk($sformatf("u%0d zero", g),    zero[g],         me.zero);
          chk($sformatf("u%0d latency", g), cyc - me.t_acc,  NDIG);
        end
      end
      prev_ov = out_valid[g];
    end

    if (g == 0) begin : dir
      initial begin
        rst_n[g] = 1'b0; in_valid[g] = 1'b0; out_ready[g] = 1'b1;
        a[g] = '0; b[g] = '0; cin[g] = 1'b0; sub[g] = 1'b0;
        #23;
        chk("reset in_ready",  in_ready[g],  1);
        chk("reset out_valid", out_valid[g], 0);
        chk("reset sum",       sum[g],       0);
        chk("reset flags",     {cout[g], ovf[g], zero[g]}, 0);
        rst_n[g] = 1'b1;
        @(negedge clk);

        send(16'h1234, 16'h0FCD, 1'b0, 1'b0, 1, mk(16'h2201, 0, 0, 0));
        send(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1, mk(16'h0000, 1, 0, 1));
        send(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1, mk(16'h8000, 0, 1, 0));
        send(16'h0005, 16'h0007, 1'b0, 1'b1, 1, mk(16'hFFFE, 0, 0, 0));
        send(16'h0007, 16'h0005, 1'b1, 1'b1, 1, mk(16'h0001, 1, 0, 0));
        send(16'h8000, 16'h0001, 1'b0, 1'b1, 1, mk(16'h7FFF, 1, 1, 0));
        send(16'h0005, 16'h0005, 1'b0, 1'b1, 1, mk(16'h0000, 1, 0, 1));
        send(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 1, mk(16'hFFFF, 1, 0, 0));
        drain();

        // Backpressure: result must hold and new operands be ignored.
        @(negedge clk);
        out_ready[g] = 1'b0;
        send(16'h1234, 16'h0FCD, 1'b0, 1'b0, 1, mk(16'h2201, 0, 0, 0));
        for (int n = 0; n < 50 && !out_valid[g]; n++) @(negedge clk);
        for (int k = 0; k < 5; k++) begin
          @(negedge clk);
          chk("hold out_valid", out_valid[g], 1);
          chk("hold in_ready",  in_ready[g],  0);
          chk("hold sum",       sum[g],       16'h2201);
          a[g] = 16'hFFFF; b[g] = 16'hFFFF; in_valid[g] = k[0];
        end
        @(negedge clk);
        chk("hold sum final", sum[g], 16'h2201);
        in_valid[g] = 1'b0;
        out_ready[g] = 1'b1;
        @(posedge clk);
        #1;
        chk("release out_valid", out_valid[g], 0);
        chk("release in_ready",  in_ready[g],  1);
        chk("release sum held",  sum[g],       16'h2201);
        drain();

        // Reset during the second RUN cycle discards the operation.
        @(negedge clk);
        send(16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 0, mk(0, 0, 0, 0));
        @(posedge clk);
        #3;
        rst_n[g] = 1'b0;
        #1;
        chk("midreset in_ready",  in_ready[g],  1);
        chk("midreset out_valid", out_valid[g], 0);
        chk("midreset sum",       sum[g],       0);
        chk("midreset flags",     {cout[g], ovf[g], zero[g]}, 0);
        @(negedge clk);
        rst_n[g] = 1'b1;
        @(negedge clk);
        send(16'h0001, 16'h0001, 1'b0, 1'b0, 1, mk(16'h0002, 0, 0, 0));
        drain();
        done[g] = 1'b1;
      end
    end else begin : rnd
      initial begin
        logic [W-1:0] ta, tb;
        logic tc, ts;
        rst_n[g] = 1'b0; in_valid[g] = 1'b0; out_ready[g] = 1'b1;
        a[g] = '0; b[g] = '0; cin[g] = 1'b0; sub[g] = 1'b0;
        #23;
        rst_n[g] = 1'b1;
        @(negedge clk);
        send(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1, mk(16'h8000, 0, 1, 0));
        send(16'h0005, 16'h0007, 1'b0, 1'b1, 1, mk(16'hFFFE, 0, 0, 0));
        for (int i = 0; i < 200; i++) begin
          ta = W'($urandom);
          tb = W'($urandom);
          tc = 1'($urandom_range(0, 1));
          ts = 1'($urandom_range(0, 1));
          send(ta, tb, tc, ts, 1, model(ta, tb, tc, ts));
        end
        drain();
        done[g] = 1'b1;
      end
    end
  end

  initial begin
    int t = 0;
    while (!(done[0] && done[1] && done[2]) && t < 60000) begin
      @(negedge clk);
      t++;
    end
    if (!(done[0] && done[1] && done[2])) begin
      checks++;
      errors++;
      $display("FAIL global_timeout: got unfinished, expected all streams done");
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
